// File: rtl/nn_pkg.sv
// Shared definitions for the binarized MLP output stage.
// Holds the class count, index width, the no-digit code, the classifier
// FSM state type and the 7-segment constants used when CLASSIFY_SEG7_EN is defined.
package nn_pkg;

    localparam int         NUM_CLASSES = 10;
    localparam int         IDX_W       = 4;
    localparam logic [3:0] NO_DIGIT    = 4'hF;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK   = 7'h7F;
    localparam logic [6:0] SEG_DASH    = 7'h3F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        FINAL = 2'd2,
        HOLD  = 2'd3
    } cls_state_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit-to-7-segment decoder (active-low, {g,f,e,d,c,b,a}).
// Digits 0..9 map to their glyphs, the no-digit code shows a centre dash,
// and any other code blanks the display. Used only when CLASSIFY_SEG7_EN is defined.
module seg7_decode
    import nn_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    // Glyph lookup for the predicted digit
    always_comb begin
        o_seg = SEG_BLANK;
        case (i_digit)
            4'd0:    o_seg = 7'h40;
            4'd1:    o_seg = 7'h79;
            4'd2:    o_seg = 7'h24;
            4'd3:    o_seg = 7'h30;
            4'd4:    o_seg = 7'h19;
            4'd5:    o_seg = 7'h12;
            4'd6:    o_seg = 7'h02;
            4'd7:    o_seg = 7'h78;
            4'd8:    o_seg = 7'h00;
            4'd9:    o_seg = 7'h10;
            NO_DIGIT: o_seg = SEG_DASH;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/classify_a3.sv
// Output stage of the binarized MLP: captures the layer-3 vector on its done
// pulse, scans it MSB-first one bit per clock, and presents the first set
// neuron as the predicted digit with an ambiguity flag and a valid/ready
// result handshake. An unaccepted result that gets overwritten sets a sticky
// overrun flag. Optional macro CLASSIFY_SEG7_EN adds a registered seg output.
module classify_a3 #(
    parameter int         NUM_CLASSES = nn_pkg::NUM_CLASSES,
    parameter logic [3:0] NO_DIGIT    = nn_pkg::NO_DIGIT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   a3_valid,
    input  logic [NUM_CLASSES-1:0] a3,
    output logic [3:0]             digit,
    output logic                   digit_ambiguous,
    output logic                   digit_valid,
    input  logic                   digit_ready,
    output logic                   busy,
`ifdef CLASSIFY_SEG7_EN
    output logic [6:0]             seg,
`endif
    output logic                   overrun
);
    import nn_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    cls_state_t             r_state, w_state_nxt;
    logic [NUM_CLASSES-1:0] r_sr, w_sr_nxt;
    logic [IDX_W-1:0]       r_idx, w_idx_nxt;
    logic [3:0]             r_ones, w_ones_nxt;
    logic [3:0]             r_first, w_first_nxt;
    logic [3:0]             r_digit, w_digit_nxt;
    logic                   r_amb, w_amb_nxt;
    logic                   r_valid, w_valid_nxt;
    logic                   r_busy, w_busy_nxt;
    logic                   r_overrun, w_overrun_nxt;
    logic                   w_load;
    logic                   w_msb;

    assign w_msb = r_sr[NUM_CLASSES-1];

    // Next-state and datapath update for the capture/scan/present sequence
    always_comb begin
        w_state_nxt   = r_state;
        w_sr_nxt      = r_sr;
        w_idx_nxt     = r_idx;
        w_ones_nxt    = r_ones;
        w_first_nxt   = r_first;
        w_digit_nxt   = r_digit;
        w_amb_nxt     = r_amb;
        w_valid_nxt   = r_valid;
        w_overrun_nxt = r_overrun;
        w_load        = 1'b0;

        case (r_state)
            IDLE: begin
                if (a3_valid) begin
                    w_load = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SCAN: begin
                w_sr_nxt  = {r_sr[NUM_CLASSES-2:0], 1'b0};
                w_idx_nxt = r_idx + {{(IDX_W-1){1'b0}}, 1'b1};
                if (w_msb) begin
                    w_ones_nxt = (r_ones == 4'hF) ? r_ones : r_ones + 4'd1;
                    if (r_first == NO_DIGIT) begin
                        w_first_nxt = 4'(r_idx);
                    end else begin
                        w_first_nxt = r_first;
                    end
                end else begin
                    w_ones_nxt = r_ones;
                end
                if (r_idx == LAST_IDX) begin
                    w_state_nxt = FINAL;
                end else begin
                    w_state_nxt = SCAN;
                end
            end
            FINAL: begin
                w_digit_nxt = r_first;
                w_amb_nxt   = (r_ones != 4'd1);
                w_valid_nxt = 1'b1;
                w_state_nxt = HOLD;
            end
            HOLD: begin
                if (digit_ready) begin
                    // Result accepted; a simultaneous new vector starts straight away
                    w_valid_nxt = 1'b0;
                    if (a3_valid) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (a3_valid) begin
                    // Pending result is lost to the new vector
                    w_overrun_nxt = 1'b1;
                    w_valid_nxt   = 1'b0;
                    w_load        = 1'b1;
                end else begin
                    w_state_nxt = HOLD;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_load) begin
            w_sr_nxt    = a3;
            w_idx_nxt   = {IDX_W{1'b0}};
            w_ones_nxt  = 4'd0;
            w_first_nxt = NO_DIGIT;
            w_state_nxt = SCAN;
        end else begin
            w_sr_nxt = w_sr_nxt;
        end

        w_busy_nxt = (w_state_nxt == SCAN) || (w_state_nxt == FINAL);
    end

    // State, scan datapath and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_sr      <= {NUM_CLASSES{1'b0}};
            r_idx     <= {IDX_W{1'b0}};
            r_ones    <= 4'd0;
            r_first   <= NO_DIGIT;
            r_digit   <= NO_DIGIT;
            r_amb     <= 1'b0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sr      <= w_sr_nxt;
            r_idx     <= w_idx_nxt;
            r_ones    <= w_ones_nxt;
            r_first   <= w_first_nxt;
            r_digit   <= w_digit_nxt;
            r_amb     <= w_amb_nxt;
            r_valid   <= w_valid_nxt;
            r_busy    <= w_busy_nxt;
            r_overrun <= w_overrun_nxt;
        end
    end

    assign digit           = r_digit;
    assign digit_ambiguous = r_amb;
    assign digit_valid     = r_valid;
    assign busy            = r_busy;
    assign overrun         = r_overrun;

`ifdef CLASSIFY_SEG7_EN
    logic [6:0] w_seg_dec;
    logic [6:0] r_seg;

    seg7_decode u_seg7_decode (
        .i_digit (r_first),
        .o_seg   (w_seg_dec)
    );

    // Segment pattern follows digit, loaded on the same FINAL edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg <= SEG_BLANK;
        end else if (r_state == FINAL) begin
            r_seg <= w_seg_dec;
        end else begin
            r_seg <= r_seg;
        end
    end

    assign seg = r_seg;
`endif

endmodule

// File: tb/tb_classify_a3.sv
// Self-checking bench for classify_a3: directed scenarios plus randomized
// vectors checked against a priority/popcount reference model.
module tb_classify_a3;

    logic       clk = 1'b0;
    logic       rst;
    logic       a3_valid;
    logic [9:0] a3;
    logic [3:0] digit;
    logic       digit_ambiguous;
    logic       digit_valid;
    logic       digit_ready;
    logic       busy;
    logic       overrun;
`ifdef CLASSIFY_SEG7_EN
    logic [6:0] seg;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    classify_a3 dut (
        .clk             (clk),
        .rst             (rst),
        .a3_valid        (a3_valid),
        .a3              (a3),
        .digit           (digit),
        .digit_ambiguous (digit_ambiguous),
        .digit_valid     (digit_valid),
        .digit_ready     (digit_ready),
        .busy            (busy),
`ifdef CLASSIFY_SEG7_EN
        .seg             (seg),
`endif
        .overrun         (overrun)
    );

    // Reference: lowest digit k whose neuron a3[9-k] is set, else 0xF
    function automatic logic [3:0] ref_digit(input logic [9:0] v);
        logic [3:0] r;
        r = 4'hF;
        for (int k = 9; k >= 0; k--) begin
            if (v[9-k]) r = 4'(k);
        end
        return r;
    endfunction

    function automatic logic ref_amb(input logic [9:0] v);
        return ($countones(v) != 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [9:0] v);
        a3       = v;
        a3_valid = 1'b1;
        tick();
        a3_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!digit_valid && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic accept();
        digit_ready = 1'b1;
        tick();
        digit_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if ({digit, digit_ambiguous, digit_valid, busy, overrun} !== {4'hF, 4'b0000}) begin
            errors++;
            $display("FAIL reset_state got %b exp %b",
                     {digit, digit_ambiguous, digit_valid, busy, overrun}, {4'hF, 4'b0000});
        end
    endtask

    task automatic test_fixed_vectors();
        logic [9:0] vecs [3];
        logic [3:0] dig  [3];
        logic       amb  [3];
        int n;
        vecs[0] = 10'b0001000000; dig[0] = 4'd3;  amb[0] = 1'b0;
        vecs[1] = 10'b0000000000; dig[1] = 4'hF;  amb[1] = 1'b1;
        vecs[2] = 10'b0010000101; dig[2] = 4'd2;  amb[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pulse(vecs[i]);
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_after_capture[%0d] got %b exp 1", i, busy);
            end
            wait_valid(n);
            checks++;
            if (n !== 11) begin
                errors++;
                $display("FAIL latency[%0d] got %0d exp 11", i, n);
            end
            checks++;
            if ({digit, digit_ambiguous} !== {dig[i], amb[i]}) begin
                errors++;
                $display("FAIL fixed_result[%0d] got digit=%0h amb=%b exp digit=%0h amb=%b",
                         i, digit, digit_ambiguous, dig[i], amb[i]);
            end
            accept();
            checks++;
            if ({digit_valid, busy} !== 2'b00) begin
                errors++;
                $display("FAIL fixed_accept[%0d] got valid=%b busy=%b exp 0 0", i, digit_valid, busy);
            end
        end
    endtask

    task automatic test_stall();
        int n;
        int bad;
        pulse(10'b0000010000);
        wait_valid(n);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!(digit_valid === 1'b1 && digit === 4'd5 && digit_ambiguous === 1'b0)) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL stall_hold got %0d unstable cycles exp 0", bad);
        end
        digit_ready = 1'b1;
        tick();
        digit_ready = 1'b0;
        checks++;
        if ({digit_valid, busy, digit} !== {2'b00, 4'd5}) begin
            errors++;
            $display("FAIL stall_release got valid=%b busy=%b digit=%0h exp 0 0 5",
                     digit_valid, busy, digit);
        end
        // Back in IDLE: a new vector must start a scan without flagging overrun
        pulse(10'b0000000100);
        checks++;
        if ({busy, overrun} !== 2'b10) begin
            errors++;
            $display("FAIL stall_idle got busy=%b overrun=%b exp 1 0", busy, overrun);
        end
        wait_valid(n);
        checks++;
        if (digit !== 4'd7) begin
            errors++;
            $display("FAIL stall_next got %0h exp 7", digit);
        end
        accept();
    endtask

    task automatic test_random();
        logic [9:0] v;
        int n;
        int st;
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 3))
                0:       v = 10'b1 << $urandom_range(0, 9);
                1:       v = (i % 2 == 0) ? 10'd0 : 10'($urandom_range(0, 1023));
                default: v = 10'($urandom_range(0, 1023));
            endcase
            pulse(v);
            wait_valid(n);
            checks++;
            if (n !== 11) begin
                errors++;
                $display("FAIL rand_latency[%0d] got %0d exp 11", i, n);
            end
            checks++;
            if ({digit, digit_ambiguous} !== {ref_digit(v), ref_amb(v)}) begin
                errors++;
                $display("FAIL rand_result[%0d] a3=%b got digit=%0h amb=%b exp digit=%0h amb=%b",
                         i, v, digit, digit_ambiguous, ref_digit(v), ref_amb(v));
            end
            st = $urandom_range(0, 3);
            for (int j = 0; j < st; j++) tick();
            checks++;
            if (digit_valid !== 1'b1) begin
                errors++;
                $display("FAIL rand_stall[%0d] got valid=%b exp 1", i, digit_valid);
            end
            accept();
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] v;
        digit_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            v = 10'($urandom_range(0, 1023));
            pulse(v);
            for (int j = 0; j < 10; j++) tick();
            checks++;
            if (digit_valid !== 1'b0) begin
                errors++;
                $display("FAIL b2b_early[%0d] got valid=%b exp 0", i, digit_valid);
            end
            tick();
            checks++;
            if ({digit_valid, digit, digit_ambiguous} !== {1'b1, ref_digit(v), ref_amb(v)}) begin
                errors++;
                $display("FAIL b2b_result[%0d] a3=%b got valid=%b digit=%0h amb=%b exp 1 %0h %b",
                         i, v, digit_valid, digit, digit_ambiguous, ref_digit(v), ref_amb(v));
            end
        end
        tick();
        digit_ready = 1'b0;
        checks++;
        if ({digit_valid, busy, overrun} !== 3'b000) begin
            errors++;
            $display("FAIL b2b_end got valid=%b busy=%b overrun=%b exp 0 0 0",
                     digit_valid, busy, overrun);
        end
    endtask

    task automatic test_overrun();
        int n;
        pulse(10'b0000000010);
        wait_valid(n);
        checks++;
        if ({digit_valid, digit, overrun} !== {1'b1, 4'd8, 1'b0}) begin
            errors++;
            $display("FAIL ovr_first got valid=%b digit=%0h overrun=%b exp 1 8 0",
                     digit_valid, digit, overrun);
        end
        pulse(10'b1000000000);
        checks++;
        if ({overrun, digit_valid, busy} !== 3'b101) begin
            errors++;
            $display("FAIL ovr_set got overrun=%b valid=%b busy=%b exp 1 0 1",
                     overrun, digit_valid, busy);
        end
        tick();
        tick();
        tick();
        // Pulse mid-scan must be ignored
        pulse(10'b0000000001);
        wait_valid(n);
        checks++;
        if (n !== 7) begin
            errors++;
            $display("FAIL ovr_latency got %0d exp 7", n);
        end
        checks++;
        if ({digit, digit_ambiguous, overrun} !== {4'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL ovr_result got digit=%0h amb=%b overrun=%b exp 0 0 1",
                     digit, digit_ambiguous, overrun);
        end
        accept();
        tick();
        checks++;
        if ({overrun, digit_valid} !== 2'b10) begin
            errors++;
            $display("FAIL ovr_sticky got overrun=%b valid=%b exp 1 0", overrun, digit_valid);
        end
    endtask

    task automatic test_reset_mid_scan();
        int n;
        int bad;
        pulse(10'b0100000000);
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({digit, digit_ambiguous, digit_valid, busy, overrun} !== {4'hF, 4'b0000}) begin
            errors++;
            $display("FAIL rst_scan_state got %b exp %b",
                     {digit, digit_ambiguous, digit_valid, busy, overrun}, {4'hF, 4'b0000});
        end
`ifdef CLASSIFY_SEG7_EN
        checks++;
        if (seg !== 7'h7F) begin
            errors++;
            $display("FAIL rst_seg got %h exp 7f", seg);
        end
`endif
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (digit_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL rst_no_result got %0d spurious cycles exp 0", bad);
        end
        pulse(10'b0000000001);
        wait_valid(n);
        checks++;
        if ({n[4:0], digit, digit_ambiguous} !== {5'd11, 4'd9, 1'b0}) begin
            errors++;
            $display("FAIL rst_clean got n=%0d digit=%0h amb=%b exp 11 9 0",
                     n, digit, digit_ambiguous);
        end
`ifdef CLASSIFY_SEG7_EN
        checks++;
        if (seg !== 7'h10) begin
            errors++;
            $display("FAIL seg_nine got %h exp 10", seg);
        end
`endif
        accept();
    endtask

    initial begin
        rst         = 1'b1;
        a3_valid    = 1'b0;
        a3          = 10'd0;
        digit_ready = 1'b0;
        test_reset();
        test_fixed_vectors();
        test_stall();
        test_random();
        test_back_to_back();
        test_overrun();
        test_reset_mid_scan();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
